// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard scheduler: FSM encoding,
// forward-select codes and default latencies.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'b00,
    ST_RUN  = 2'b01,
    ST_MDU  = 2'b10
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam int DEF_MDU_LATENCY = 4;
  localparam int DEF_RESET_HOLD  = 2;

  // Register 0 is hard-wired, so it never participates in a hazard.
  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational forwarding-select logic for the ID compare operands and the
// EX ALU operands.
module hazard_fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_d,
  input  logic [4:0] rt_d,
  input  logic [4:0] rs_e,
  input  logic [4:0] rt_e,
  input  logic [4:0] write_reg_m,
  input  logic       reg_write_m,
  input  logic       mem_read_m,
  input  logic [4:0] write_reg_w,
  input  logic       reg_write_w,
  output logic       fwd_a_d,
  output logic       fwd_b_d,
  output logic [1:0] fwd_a_e,
  output logic [1:0] fwd_b_e
);

  // ID operands can only take an ALU result from MEM; a load's data is not ready yet.
  always_comb begin
    fwd_a_d = reg_write_m & ~mem_read_m & reg_hit(write_reg_m, rs_d);
    fwd_b_d = reg_write_m & ~mem_read_m & reg_hit(write_reg_m, rt_d);
  end

  // EX operands: the youngest producer (MEM) wins over WB.
  always_comb begin
    if (reg_write_m && reg_hit(write_reg_m, rs_e)) begin
      fwd_a_e = FWD_M;
    end else if (reg_write_w && reg_hit(write_reg_w, rs_e)) begin
      fwd_a_e = FWD_W;
    end else begin
      fwd_a_e = FWD_RF;
    end
    if (reg_write_m && reg_hit(write_reg_m, rt_e)) begin
      fwd_b_e = FWD_M;
    end else if (reg_write_w && reg_hit(write_reg_w, rt_e)) begin
      fwd_b_e = FWD_W;
    end else begin
      fwd_b_e = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_sched.sv
// Central hazard scheduler: stall/flush/forward control, MDU sequencing and
// post-reset drain. Optional stall counters under HAZARD_SCHED_PERF_EN.
module hazard_sched
  import hazard_pkg::*;
#(
  parameter int MDU_LATENCY = DEF_MDU_LATENCY,
  parameter int RESET_HOLD  = DEF_RESET_HOLD
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic        UseRsD,
  input  logic        UseRtD,
  input  logic        BranchD,
  input  logic        JrD,
  input  logic [2:0]  PCSrcD,
  input  logic        MduUseD,
  input  logic [4:0]  rsE,
  input  logic [4:0]  rtE,
  input  logic [4:0]  WriteRegE,
  input  logic        RegWriteE,
  input  logic        MemReadE,
  input  logic        MduStartE,
  input  logic [4:0]  WriteRegM,
  input  logic        RegWriteM,
  input  logic        MemReadM,
  input  logic [4:0]  WriteRegW,
  input  logic        RegWriteW,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic        ForwardAD,
  output logic        ForwardBD,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
`ifdef HAZARD_SCHED_PERF_EN
  output logic [31:0] LwStallCnt,
  output logic [31:0] BrStallCnt,
  output logic [31:0] MduStallCnt,
`endif
  output logic        MduBusy
);

  localparam logic [2:0] HOLD_LAST = 3'(RESET_HOLD - 1);
  localparam logic [3:0] MDU_LAST  = 4'(MDU_LATENCY - 1);

  state_e     state_q, state_d;
  logic [2:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] mdu_cnt_q, mdu_cnt_d;
  logic       mdu_busy_q, mdu_busy_d;
  logic       lw_stall, br_stall, mdu_stall, any_stall;
  logic       fwd_a_d, fwd_b_d;
  logic [1:0] fwd_a_e, fwd_b_e;

  function automatic logic src_hit(input logic [4:0] dst, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic use_rs,
                                   input logic use_rt);
    return (use_rs & reg_hit(dst, rs)) | (use_rt & reg_hit(dst, rt));
  endfunction

  hazard_fwd_unit u_fwd (
    .rs_d        (rsD),
    .rt_d        (rtD),
    .rs_e        (rsE),
    .rt_e        (rtE),
    .write_reg_m (WriteRegM),
    .reg_write_m (RegWriteM),
    .mem_read_m  (MemReadM),
    .write_reg_w (WriteRegW),
    .reg_write_w (RegWriteW),
    .fwd_a_d     (fwd_a_d),
    .fwd_b_d     (fwd_b_d),
    .fwd_a_e     (fwd_a_e),
    .fwd_b_e     (fwd_b_e)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= 3'd0;
      mdu_cnt_q  <= 4'd0;
      mdu_busy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      mdu_cnt_q  <= mdu_cnt_d;
      mdu_busy_q <= mdu_busy_d;
    end
  end

  // A start seen while already in MDU is ignored; the decode stall keeps it from happening.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    mdu_cnt_d  = mdu_cnt_q;
    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_RUN;
          hold_cnt_d = 3'd0;
        end else begin
          hold_cnt_d = hold_cnt_q + 3'd1;
        end
      end
      ST_RUN: begin
        mdu_cnt_d = 4'd0;
        if (MduStartE) begin
          state_d = ST_MDU;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MDU: begin
        if (mdu_cnt_q == MDU_LAST) begin
          state_d   = ST_RUN;
          mdu_cnt_d = 4'd0;
        end else begin
          mdu_cnt_d = mdu_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = 3'd0;
        mdu_cnt_d  = 4'd0;
      end
    endcase
    mdu_busy_d = (state_d == ST_MDU);
  end

  // A branch right after a load stalls once on lwStall and once more on brStall from MEM.
  always_comb begin
    lw_stall  = MemReadE & src_hit(WriteRegE, rsD, rtD, UseRsD, UseRtD);
    br_stall  = (BranchD | JrD) &
                ((RegWriteE & src_hit(WriteRegE, rsD, rtD, UseRsD, UseRtD)) |
                 (MemReadM  & src_hit(WriteRegM, rsD, rtD, UseRsD, UseRtD)));
    mdu_stall = MduUseD & (mdu_busy_q | MduStartE);
    any_stall = lw_stall | br_stall | mdu_stall;
  end

  always_comb begin
    case (state_q)
      ST_RUN, ST_MDU: begin
        StallF    = any_stall;
        StallD    = any_stall;
        FlushE    = any_stall;
        FlushD    = (PCSrcD != 3'd0) & ~any_stall;
        ForwardAD = fwd_a_d;
        ForwardBD = fwd_b_d;
        ForwardAE = fwd_a_e;
        ForwardBE = fwd_b_e;
      end
      default: begin
        StallF    = 1'b1;
        StallD    = 1'b1;
        FlushE    = 1'b1;
        FlushD    = 1'b1;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
      end
    endcase
    MduBusy = mdu_busy_q;
  end

`ifdef HAZARD_SCHED_PERF_EN
  logic [31:0] lw_cnt_q, lw_cnt_d, br_cnt_q, br_cnt_d, mdu_scnt_q, mdu_scnt_d;
  logic        active;

  // Only the highest-priority cause is charged for a stalled cycle.
  always_comb begin
    active     = (state_q == ST_RUN) || (state_q == ST_MDU);
    lw_cnt_d   = lw_cnt_q;
    br_cnt_d   = br_cnt_q;
    mdu_scnt_d = mdu_scnt_q;
    if (active && lw_stall) begin
      lw_cnt_d = lw_cnt_q + 32'd1;
    end else if (active && br_stall) begin
      br_cnt_d = br_cnt_q + 32'd1;
    end else if (active && mdu_stall) begin
      mdu_scnt_d = mdu_scnt_q + 32'd1;
    end else begin
      lw_cnt_d = lw_cnt_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      lw_cnt_q   <= 32'd0;
      br_cnt_q   <= 32'd0;
      mdu_scnt_q <= 32'd0;
    end else begin
      lw_cnt_q   <= lw_cnt_d;
      br_cnt_q   <= br_cnt_d;
      mdu_scnt_q <= mdu_scnt_d;
    end
  end

  assign LwStallCnt  = lw_cnt_q;
  assign BrStallCnt  = br_cnt_q;
  assign MduStallCnt = mdu_scnt_q;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: directed test-plan steps followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_hazard_sched;

  localparam int LAT  = 4;
  localparam int HOLD = 2;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [4:0] rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
  logic       UseRsD, UseRtD, BranchD, JrD, MduUseD;
  logic [2:0] PCSrcD;
  logic       RegWriteE, MemReadE, MduStartE, RegWriteM, MemReadM, RegWriteW;
  logic       StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD, MduBusy;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_SCHED_PERF_EN
  logic [31:0] LwStallCnt, BrStallCnt, MduStallCnt;
  int          m_lw_cnt, m_br_cnt, m_mdu_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Behavioural model state: drain phase and remaining MDU busy cycles.
  bit m_in_hold;
  int m_hold_elapsed;
  int m_mdu_rem;
  bit e_lw, e_br, e_mdu, e_stall;

  always #5 Clock = ~Clock;

  hazard_sched #(.MDU_LATENCY(LAT), .RESET_HOLD(HOLD)) dut (
    .Clock(Clock), .Reset(Reset), .rsD(rsD), .rtD(rtD), .UseRsD(UseRsD),
    .UseRtD(UseRtD), .BranchD(BranchD), .JrD(JrD), .PCSrcD(PCSrcD),
    .MduUseD(MduUseD), .rsE(rsE), .rtE(rtE), .WriteRegE(WriteRegE),
    .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MduStartE(MduStartE),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemReadM(MemReadM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .StallF(StallF),
    .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .ForwardAD(ForwardAD),
    .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
`ifdef HAZARD_SCHED_PERF_EN
    .LwStallCnt(LwStallCnt), .BrStallCnt(BrStallCnt), .MduStallCnt(MduStallCnt),
`endif
    .MduBusy(MduBusy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Does register r feed a source the ID instruction actually reads?
  function automatic bit reads(input logic [4:0] r);
    return (r != 5'd0) && ((UseRsD && r == rsD) || (UseRtD && r == rtD));
  endfunction

  function automatic logic [1:0] ex_src(input logic [4:0] src);
    if (src != 5'd0 && RegWriteM && WriteRegM == src) return 2'b10;
    if (src != 5'd0 && RegWriteW && WriteRegW == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_eval();
    e_lw    = MemReadE && reads(WriteRegE);
    e_br    = (BranchD || JrD) && ((RegWriteE && reads(WriteRegE)) || (MemReadM && reads(WriteRegM)));
    e_mdu   = MduUseD && (m_mdu_rem > 0 || MduStartE);
    e_stall = e_lw || e_br || e_mdu;
  endtask

  task automatic compare_model();
    bit ad, bd;
    model_eval();
    ad = RegWriteM && !MemReadM && WriteRegM != 5'd0 && WriteRegM == rsD;
    bd = RegWriteM && !MemReadM && WriteRegM != 5'd0 && WriteRegM == rtD;
    check("StallF", StallF, m_in_hold ? 1 : e_stall);
    check("StallD", StallD, m_in_hold ? 1 : e_stall);
    check("FlushE", FlushE, m_in_hold ? 1 : e_stall);
    check("FlushD", FlushD, m_in_hold ? 1 : (PCSrcD != 3'd0 && !e_stall));
    check("ForwardAD", ForwardAD, m_in_hold ? 0 : ad);
    check("ForwardBD", ForwardBD, m_in_hold ? 0 : bd);
    check("ForwardAE", ForwardAE, m_in_hold ? 2'b00 : ex_src(rsE));
    check("ForwardBE", ForwardBE, m_in_hold ? 2'b00 : ex_src(rtE));
    check("MduBusy", MduBusy, m_mdu_rem > 0);
`ifdef HAZARD_SCHED_PERF_EN
    check("LwStallCnt", LwStallCnt, m_lw_cnt);
    check("BrStallCnt", BrStallCnt, m_br_cnt);
    check("MduStallCnt", MduStallCnt, m_mdu_cnt);
`endif
  endtask

  task automatic model_advance();
    model_eval();
    if (Reset) begin
      m_in_hold = 1; m_hold_elapsed = 0; m_mdu_rem = 0;
`ifdef HAZARD_SCHED_PERF_EN
      m_lw_cnt = 0; m_br_cnt = 0; m_mdu_cnt = 0;
`endif
    end else begin
`ifdef HAZARD_SCHED_PERF_EN
      if (!m_in_hold) begin
        if (e_lw) m_lw_cnt++;
        else if (e_br) m_br_cnt++;
        else if (e_mdu) m_mdu_cnt++;
      end
`endif
      if (m_in_hold) begin
        m_hold_elapsed++;
        if (m_hold_elapsed == HOLD) m_in_hold = 0;
      end else if (m_mdu_rem > 0) begin
        m_mdu_rem--;
      end else if (MduStartE) begin
        m_mdu_rem = LAT;
      end
    end
  endtask

  task automatic sample();
    @(negedge Clock);
    compare_model();
  endtask

  task automatic tick();
    @(posedge Clock);
    model_advance();
    #1;
  endtask

  task automatic idle();
    rsD = 5'd0; rtD = 5'd0; UseRsD = 1'b0; UseRtD = 1'b0; BranchD = 1'b0; JrD = 1'b0;
    PCSrcD = 3'd0; MduUseD = 1'b0; rsE = 5'd0; rtE = 5'd0; WriteRegE = 5'd0;
    RegWriteE = 1'b0; MemReadE = 1'b0; MduStartE = 1'b0; WriteRegM = 5'd0;
    RegWriteM = 1'b0; MemReadM = 1'b0; WriteRegW = 5'd0; RegWriteW = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  initial begin
    m_in_hold = 1; m_hold_elapsed = 0; m_mdu_rem = 0;
`ifdef HAZARD_SCHED_PERF_EN
    m_lw_cnt = 0; m_br_cnt = 0; m_mdu_cnt = 0;
`endif
    idle();
    Reset = 1'b1;
    @(posedge Clock); #1;

    // Reset held for three cycles, then the two-cycle drain.
    for (int i = 0; i < 3; i++) begin
      sample(); check("rst_stallF", StallF, 1); check("rst_busy", MduBusy, 0); tick();
    end
    Reset = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      sample(); check("hold_stallF", StallF, 1); check("hold_flushD", FlushD, 1); tick();
    end
    sample(); check("run_stallF", StallF, 0); check("run_flushD", FlushD, 0); tick();

    // Load-use: one stall, then WB forwarding into EX.
    MemReadE = 1; RegWriteE = 1; WriteRegE = 5'd8; rsD = 5'd8; UseRsD = 1;
    sample(); check("lw_stall", StallD, 1); check("lw_flushE", FlushE, 1); tick();
    idle(); MemReadM = 1; RegWriteM = 1; WriteRegM = 5'd8; rsD = 5'd8; UseRsD = 1;
    sample(); check("lw_release", StallF, 0); tick();
    idle(); rsE = 5'd8; RegWriteW = 1; WriteRegW = 5'd8;
    sample(); check("lw_fwdAE", ForwardAE, 2'b01); tick();

    // Branch after load: lwStall, then brStall, then redirect honoured.
    idle(); MemReadE = 1; RegWriteE = 1; WriteRegE = 5'd9; BranchD = 1;
    rsD = 5'd9; UseRsD = 1; UseRtD = 1; PCSrcD = 3'b001;
    sample(); check("beq_stall1", StallF, 1); check("beq_noflush1", FlushD, 0); tick();
    MemReadE = 0; RegWriteE = 0; WriteRegE = 5'd0;
    MemReadM = 1; RegWriteM = 1; WriteRegM = 5'd9;
    sample(); check("beq_stall2", StallF, 1); check("beq_noflush2", FlushD, 0); tick();
    MemReadM = 0; RegWriteM = 0; WriteRegM = 5'd0; RegWriteW = 1; WriteRegW = 5'd9;
    sample(); check("beq_go", StallF, 0); check("beq_fwdAD", ForwardAD, 0);
    check("beq_flushD", FlushD, 1); tick();

    // jr using an ALU result in MEM: forwarded, no stall, redirect.
    idle(); RegWriteM = 1; WriteRegM = 5'd3; JrD = 1; rsD = 5'd3; UseRsD = 1; PCSrcD = 3'b011;
    sample(); check("jr_fwdAD", ForwardAD, 1); check("jr_stall", StallF, 0);
    check("jr_flushD", FlushD, 1); tick();

    // MDU start then mfhi: stall through start + LAT busy cycles.
    idle(); MduStartE = 1; MduUseD = 1;
    sample(); check("mdu_start_stall", StallD, 1); check("mdu_start_busy", MduBusy, 0); tick();
    MduStartE = 0;
    for (int i = 0; i < LAT; i++) begin
      sample(); check("mdu_busy", MduBusy, 1); check("mdu_stall", StallD, 1); tick();
    end
    sample(); check("mdu_done_busy", MduBusy, 0); check("mdu_done_stall", StallD, 0); tick();

    // Reset on the second busy cycle aborts the operation.
    idle(); MduStartE = 1;
    sample(); tick();
    MduStartE = 0;
    sample(); check("abort_busy1", MduBusy, 1); tick();
    Reset = 1;
    sample(); check("abort_busy2", MduBusy, 1); tick();
    sample(); check("abort_cleared", MduBusy, 0); check("abort_hold", StallF, 1); tick();
    Reset = 0;
    for (int i = 0; i < HOLD; i++) begin
      sample(); check("rehold_flushD", FlushD, 1); tick();
    end
    sample(); check("rehold_run", StallF, 0); tick();

    // Randomized traffic on a small register window to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      Reset     = ($urandom_range(0, 59) == 0);
      rsD       = 5'($urandom_range(0, 3));
      rtD       = 5'($urandom_range(0, 3));
      UseRsD    = 1'($urandom);
      UseRtD    = 1'($urandom);
      BranchD   = ($urandom_range(0, 3) == 0);
      JrD       = ($urandom_range(0, 5) == 0);
      PCSrcD    = 3'($urandom_range(0, 7));
      MduUseD   = ($urandom_range(0, 2) == 0);
      rsE       = 5'($urandom_range(0, 3));
      rtE       = 5'($urandom_range(0, 3));
      WriteRegE = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom);
      MemReadE  = ($urandom_range(0, 2) == 0);
      MduStartE = ($urandom_range(0, 9) == 0);
      WriteRegM = 5'($urandom_range(0, 3));
      RegWriteM = 1'($urandom);
      MemReadM  = ($urandom_range(0, 2) == 0);
      WriteRegW = 5'($urandom_range(0, 3));
      RegWriteW = 1'($urandom);
      sample(); tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
